bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares the CPU-mastered system bus (addr/data/rd_n/wr_n/mreq_n/iorq_n) between the CPU and N_REQ secondary bus masters (DMA, debug/loader engines).
- Requests the bus from the CPU with busrq_n and waits for busack_n.
- Grants the bus to one requester at a time, round-robin.
- Returns the bus to the CPU when no requests remain.
- Sits beside cpu on the shared bus; same clock as the CPU.

Parameters:
- N_REQ, 2, number of secondary requesters (1..8).
- MAX_HOLD, 0, grant-hold cycle limit before yield is asserted; 0 disables the limit.
- CNT_WIDTH, 16, width of the hold counter; MAX_HOLD must be < 2**CNT_WIDTH.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester bus request, level; held until done.
- gnt  out  N_REQ  one-hot grant; requester may drive the bus only while its bit is 1.
- yield  out  N_REQ  hold limit reached; the owner must drop req at its next cycle boundary.
- owner  out  max(1,$clog2(N_REQ))  index of the current or last grantee.
- owner_valid  out  1  equals |gnt.
- busrq_n  out  1  bus request to the CPU, active-low.
- busack_n  in  1  bus acknowledge from the CPU, active-low; same clock domain, no synchroniser.
- err  out  1  sticky protocol-error flag.

Behaviour:
- All outputs are registered.
- Reset values: gnt=0, yield=0, owner=0, owner_valid=0, busrq_n=1, err=0, state=IDLE, rr pointer=0, hold counter=0.
- Reset asserted mid-operation drops gnt and busrq_n immediately. This is asynchronous and no handback sequence is performed.
- Round-robin arbitration:
  - Search starts at index rr+1 mod N_REQ.
  - The first set req wins.
  - On each grant, rr := winner.
- States:
  - IDLE:
    - busrq_n=1.
    - If |req, go to REQ_CPU; busrq_n=0 from the next cycle.
  - REQ_CPU:
    - busrq_n=0; wait for busack_n==0 to be sampled.
    - On that edge, arbitrate among the current req.
    - If a winner exists: go to GRANT, set gnt[winner]=1 and owner=winner, counter=0.
    - If req==0 at that edge: go to HANDBACK.
  - GRANT:
    - busrq_n=0; counter increments each cycle, saturating.
    - If MAX_HOLD!=0 and counter==MAX_HOLD-1: yield[owner]=1 from the next cycle, held until exit.
    - If req[owner]==0: go to RELEASE; gnt=0 and yield=0 next cycle.
    - Requests from other requesters never revoke the grant.
  - RELEASE:
    - Exactly one turnaround cycle with gnt=0 and busrq_n=0.
    - Arbitrate; the just-released index has lowest priority via rr.
    - If a winner exists: go to GRANT (direct handoff without returning the bus to the CPU), counter=0.
    - Otherwise: go to HANDBACK.
  - HANDBACK:
    - busrq_n=1; wait for busack_n==1 to be sampled, then go to IDLE.
    - Requests arriving here are serviced only after returning to IDLE, so the CPU always regains the bus.
- Latency:
  - req rising at edge t → busrq_n low after edge t+1.
  - busack_n low sampled at edge k → gnt visible after edge k.
  - req drop sampled at edge m → gnt low after edge m.
  - Next gnt (handoff) after edge m+1.
- Protocol error: busack_n==1 sampled in GRANT or RELEASE means the CPU took the bus back.
  - gnt=0 and yield=0 next cycle; go to HANDBACK; err=1.
  - err stays set until reset.
- Invariants:
  - gnt is at most one-hot.
  - gnt!=0 implies busrq_n==0.
  - gnt!=0 only while the previous busack_n sample was 0.
- N_REQ=1: round-robin degenerates to a fixed grant; owner is always 0.

Test Plan:
- Single request: N_REQ=2; hold busack_n = busrq_n delayed 2 cycles; req=01 at edge 0.
  - busrq_n=0 after edge 1; gnt=01 after the first edge sampling busack_n=0.
  - Drop req → gnt=00 next edge, busrq_n=1 two edges later, then IDLE once busack_n=1.
- Round-robin: req=11 held continuously, each owner drops req for 1 cycle after 4 granted cycles then re-raises.
  - Grant order 01,10,01,10.
  - Each handoff has one gnt=00 cycle; busrq_n stays 0 throughout.
- Hold limit: MAX_HOLD=8; req[0] held.
  - yield[0]=1 after the 8th granted cycle.
  - Owner drops req → gnt and yield clear next edge.
- Late CPU acknowledge: busack_n held 1 for 20 cycles after busrq_n=0.
  - gnt stays 00 and busrq_n stays 0 for all 20 cycles.
  - gnt asserted the edge after busack_n=0.
- Protocol error: busack_n forced to 1 during GRANT.
  - gnt=00 next edge, err=1, busrq_n=1.
  - err stays 1 through later transactions.
- Reset mid-grant: assert reset while gnt=10.
  - gnt=00, busrq_n=1, err=0 immediately, without waiting for a clock edge.
  - After release, req=10 is granted normally.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Bus-sharing handshake between the arbiter, its secondary masters and the CPU.
// The master modport is the arbiter side; the slave modport is the requester/CPU side.
interface bus_arbiter_if #(
   parameter int unsigned N_REQ = 2
);
   localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic [N_REQ-1:0] yield;
   logic [OW-1:0]    owner;
   logic             owner_valid;
   logic             busrq_n;
   logic             busack_n;
   logic             err;

   modport master (
      input  req,
      input  busack_n,
      output gnt,
      output yield,
      output owner,
      output owner_valid,
      output busrq_n,
      output err
   );

   modport slave (
      output req,
      output busack_n,
      input  gnt,
      input  yield,
      input  owner,
      input  owner_valid,
      input  busrq_n,
      input  err
   );
endinterface

// File: rtl/bus_arbiter.sv
// Borrows the CPU bus via busrq_n/busack_n and lends it round-robin to N_REQ secondary
// masters, handing it back to the CPU once no requests remain.
module bus_arbiter #(
   parameter int unsigned N_REQ     = 2,
   parameter int unsigned MAX_HOLD  = 0,
   parameter int unsigned CNT_WIDTH = 16
) (
   input logic           clk_i,
   input logic           reset_i,
   bus_arbiter_if.master bus_io
);
   localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [CNT_WIDTH-1:0] HoldLast =
      (MAX_HOLD == 0) ? '0 : CNT_WIDTH'(MAX_HOLD - 1);

   typedef enum logic [2:0] {
      StIdle,
      StReqCpu,
      StGrant,
      StRelease,
      StHandback
   } state_e;

   state_e                 state_q, state_d;
   logic [N_REQ-1:0]       gnt_q, gnt_d;
   logic [N_REQ-1:0]       yield_q, yield_d;
   logic [OW-1:0]          owner_q, owner_d;
   logic                   owner_valid_q, owner_valid_d;
   logic                   busrq_n_q, busrq_n_d;
   logic                   err_q, err_d;
   logic [OW-1:0]          rr_q, rr_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

   logic                   found;
   logic [OW-1:0]          win;
   logic [OW-1:0]          cand;

   // Round-robin search starting just after the last grantee.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         cand = OW'((32'(rr_q) + i) % N_REQ);
         if (!found && bus_io.req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      yield_d   = yield_q;
      owner_d   = owner_q;
      busrq_n_d = busrq_n_q;
      err_d     = err_q;
      rr_d      = rr_q;
      cnt_d     = cnt_q;

      unique case (state_q)
         StIdle: begin
            busrq_n_d = 1'b1;
            if (|bus_io.req) begin
               state_d   = StReqCpu;
               busrq_n_d = 1'b0;
            end
         end
         StReqCpu: begin
            busrq_n_d = 1'b0;
            if (!bus_io.busack_n) begin
               if (found) begin
                  state_d = StGrant;
                  gnt_d   = N_REQ'(1) << win;
                  owner_d = win;
                  rr_d    = win;
                  cnt_d   = '0;
               end else begin
                  state_d   = StHandback;
                  busrq_n_d = 1'b1;
               end
            end
         end
         StGrant: begin
            if (bus_io.busack_n) begin
               // CPU reclaimed the bus while we held it.
               state_d   = StHandback;
               gnt_d     = '0;
               yield_d   = '0;
               busrq_n_d = 1'b1;
               err_d     = 1'b1;
            end else if (!bus_io.req[owner_q]) begin
               state_d = StRelease;
               gnt_d   = '0;
               yield_d = '0;
            end else begin
               if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
               if (MAX_HOLD != 0 && cnt_q == HoldLast) yield_d = N_REQ'(1) << owner_q;
            end
         end
         StRelease: begin
            if (bus_io.busack_n) begin
               state_d   = StHandback;
               gnt_d     = '0;
               yield_d   = '0;
               busrq_n_d = 1'b1;
               err_d     = 1'b1;
            end else if (found) begin
               // Direct handoff; the CPU never sees the bus in between.
               state_d = StGrant;
               gnt_d   = N_REQ'(1) << win;
               owner_d = win;
               rr_d    = win;
               cnt_d   = '0;
            end else begin
               state_d   = StHandback;
               busrq_n_d = 1'b1;
            end
         end
         StHandback: begin
            busrq_n_d = 1'b1;
            if (bus_io.busack_n) state_d = StIdle;
         end
         default: begin
            state_d   = StIdle;
            gnt_d     = '0;
            yield_d   = '0;
            busrq_n_d = 1'b1;
         end
      endcase

      owner_valid_d = |gnt_d;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= StIdle;
         gnt_q         <= '0;
         yield_q       <= '0;
         owner_q       <= '0;
         owner_valid_q <= 1'b0;
         busrq_n_q     <= 1'b1;
         err_q         <= 1'b0;
         rr_q          <= '0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         yield_q       <= yield_d;
         owner_q       <= owner_d;
         owner_valid_q <= owner_valid_d;
         busrq_n_q     <= busrq_n_d;
         err_q         <= err_d;
         rr_q          <= rr_d;
         cnt_q         <= cnt_d;
      end
   end

   assign bus_io.gnt         = gnt_q;
   assign bus_io.yield       = yield_q;
   assign bus_io.owner       = owner_q;
   assign bus_io.owner_valid = owner_valid_q;
   assign bus_io.busrq_n     = busrq_n_q;
   assign bus_io.err         = err_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (N_REQ=2, MAX_HOLD=8) with a CPU model that
// acknowledges busrq_n two cycles late, or a forced busack_n level.
module tb_bus_arbiter;
   logic clk;
   logic reset;
   logic ack_auto;
   logic ack_force;
   logic d1, d2;
   int   checks;
   int   failures;

   bus_arbiter_if #(.N_REQ(2)) bus_if ();

   bus_arbiter #(
      .N_REQ    (2),
      .MAX_HOLD (8),
      .CNT_WIDTH(16)
   ) dut (
      .clk_i  (clk),
      .reset_i(reset),
      .bus_io (bus_if)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; CPU model updates busack_n just after the edge.
   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         if (ack_auto) begin
            bus_if.busack_n = d2;
            d2 = d1;
            d1 = bus_if.busrq_n;
         end else begin
            bus_if.busack_n = ack_force;
         end
      end
   endtask

   initial begin
      logic [1:0] exp_gnt;
      logic [1:0] cur;
      checks          = 0;
      failures        = 0;
      clk             = 1'b0;
      reset           = 1'b1;
      ack_auto        = 1'b1;
      ack_force       = 1'b1;
      d1              = 1'b1;
      d2              = 1'b1;
      bus_if.req      = 2'b00;
      bus_if.busack_n = 1'b1;

      #2;
      chk("rst_gnt", 32'(bus_if.gnt), 32'h0);
      chk("rst_yield", 32'(bus_if.yield), 32'h0);
      chk("rst_owner", 32'(bus_if.owner), 32'h0);
      chk("rst_owner_valid", 32'(bus_if.owner_valid), 32'h0);
      chk("rst_busrq_n", 32'(bus_if.busrq_n), 32'h1);
      chk("rst_err", 32'(bus_if.err), 32'h0);
      #10 reset = 1'b0;

      // Single request
      tick(1);
      bus_if.req = 2'b01;
      tick(1);
      chk("single_busrq_low", 32'(bus_if.busrq_n), 32'h0);
      chk("single_no_gnt_e1", 32'(bus_if.gnt), 32'h0);
      tick(2);
      chk("single_no_gnt_e3", 32'(bus_if.gnt), 32'h0);
      tick(1);
      chk("single_gnt", 32'(bus_if.gnt), 32'h1);
      chk("single_owner", 32'(bus_if.owner), 32'h0);
      chk("single_owner_valid", 32'(bus_if.owner_valid), 32'h1);
      tick(1);
      chk("single_gnt_held", 32'(bus_if.gnt), 32'h1);
      bus_if.req = 2'b00;
      tick(1);
      chk("single_drop_gnt", 32'(bus_if.gnt), 32'h0);
      chk("single_drop_valid", 32'(bus_if.owner_valid), 32'h0);
      chk("single_drop_busrq", 32'(bus_if.busrq_n), 32'h0);
      tick(1);
      chk("single_handback", 32'(bus_if.busrq_n), 32'h1);
      tick(1);
      bus_if.req = 2'b10;  // arrives during HANDBACK
      tick(1);
      chk("hb_ignores_req", 32'(bus_if.busrq_n), 32'h1);
      tick(1);
      chk("hb_to_idle", 32'(bus_if.busrq_n), 32'h1);
      tick(1);
      chk("idle_rerequest", 32'(bus_if.busrq_n), 32'h0);
      tick(2);
      chk("req10_wait_ack", 32'(bus_if.gnt), 32'h0);
      tick(1);
      chk("req10_gnt", 32'(bus_if.gnt), 32'h2);
      chk("req10_owner", 32'(bus_if.owner), 32'h1);

      // Round-robin with both requesters active
      bus_if.req = 2'b11;
      tick(1);
      chk("rr_no_revoke", 32'(bus_if.gnt), 32'h2);
      tick(2);
      cur = 2'b10;
      for (int r = 0; r < 4; r++) begin
         exp_gnt = (r % 2 == 0) ? 2'b01 : 2'b10;
         bus_if.req = 2'b11 & ~cur;
         tick(1);
         chk("rr_turnaround_gnt", 32'(bus_if.gnt), 32'h0);
         chk("rr_turnaround_busrq", 32'(bus_if.busrq_n), 32'h0);
         bus_if.req = 2'b11;
         tick(1);
         chk("rr_order_gnt", 32'(bus_if.gnt), 32'(exp_gnt));
         chk("rr_order_owner", 32'(bus_if.owner), (r % 2 == 0) ? 32'h0 : 32'h1);
         for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("rr_hold_busrq", 32'(bus_if.busrq_n), 32'h0);
            chk("rr_hold_yield", 32'(bus_if.yield), 32'h0);
         end
         cur = exp_gnt;
      end

      // Hold limit: only requester 0
      bus_if.req = 2'b01;
      tick(1);
      chk("hold_turnaround", 32'(bus_if.gnt), 32'h0);
      tick(1);
      chk("hold_gnt", 32'(bus_if.gnt), 32'h1);
      for (int k = 0; k < 7; k++) begin
         tick(1);
         chk("hold_no_yield", 32'(bus_if.yield), 32'h0);
      end
      tick(1);
      chk("hold_yield", 32'(bus_if.yield), 32'h1);
      chk("hold_gnt_kept", 32'(bus_if.gnt), 32'h1);
      tick(1);
      chk("hold_yield_held", 32'(bus_if.yield), 32'h1);
      bus_if.req = 2'b00;
      tick(1);
      chk("hold_drop_gnt", 32'(bus_if.gnt), 32'h0);
      chk("hold_drop_yield", 32'(bus_if.yield), 32'h0);
      tick(1);
      chk("hold_handback", 32'(bus_if.busrq_n), 32'h1);
      tick(5);

      // Late CPU acknowledge
      ack_auto   = 1'b0;
      ack_force  = 1'b1;
      bus_if.req = 2'b01;
      tick(1);
      chk("late_busrq", 32'(bus_if.busrq_n), 32'h0);
      for (int k = 0; k < 20; k++) begin
         tick(1);
         chk("late_no_gnt", 32'(bus_if.gnt), 32'h0);
         chk("late_busrq_held", 32'(bus_if.busrq_n), 32'h0);
      end
      ack_force       = 1'b0;
      bus_if.busack_n = 1'b0;
      tick(1);
      chk("late_gnt", 32'(bus_if.gnt), 32'h1);
      tick(1);

      // Protocol error: CPU drops acknowledge mid-grant
      ack_force       = 1'b1;
      bus_if.busack_n = 1'b1;
      tick(1);
      chk("perr_gnt", 32'(bus_if.gnt), 32'h0);
      chk("perr_err", 32'(bus_if.err), 32'h1);
      chk("perr_busrq", 32'(bus_if.busrq_n), 32'h1);
      chk("perr_valid", 32'(bus_if.owner_valid), 32'h0);
      tick(1);
      chk("perr_idle_busrq", 32'(bus_if.busrq_n), 32'h1);
      tick(1);
      chk("perr_rerequest", 32'(bus_if.busrq_n), 32'h0);
      ack_force       = 1'b0;
      bus_if.busack_n = 1'b0;
      tick(1);
      chk("perr_regrant", 32'(bus_if.gnt), 32'h1);
      chk("perr_err_sticky", 32'(bus_if.err), 32'h1);

      // Reset while requester 1 owns the bus
      bus_if.req = 2'b10;
      tick(1);
      chk("rstmid_turnaround", 32'(bus_if.gnt), 32'h0);
      tick(1);
      chk("rstmid_gnt10", 32'(bus_if.gnt), 32'h2);
      #2 reset = 1'b1;
      #1;
      chk("rstmid_gnt", 32'(bus_if.gnt), 32'h0);
      chk("rstmid_busrq", 32'(bus_if.busrq_n), 32'h1);
      chk("rstmid_err", 32'(bus_if.err), 32'h0);
      chk("rstmid_valid", 32'(bus_if.owner_valid), 32'h0);
      #2 reset = 1'b0;
      ack_auto        = 1'b1;
      d1              = 1'b1;
      d2              = 1'b1;
      bus_if.busack_n = 1'b1;
      tick(1);
      chk("post_rst_busrq", 32'(bus_if.busrq_n), 32'h0);
      tick(2);
      chk("post_rst_wait", 32'(bus_if.gnt), 32'h0);
      tick(1);
      chk("post_rst_gnt", 32'(bus_if.gnt), 32'h2);
      chk("post_rst_owner", 32'(bus_if.owner), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
